// File: rtl/conv_mac_pkg.sv
// Shared widths, sideband bundle, FSM states and saturation limits
// for the pipelined multiply-accumulate block.
package conv_mac_pkg;

  localparam int DIN0_W = 8;
  localparam int DIN1_W = 14;
  localparam int ACC_W  = 32;
  localparam int NSTAGE = 3;
  localparam int CNT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
    logic mode;
  } side_t;

  // Limits for a w-bit accumulator, w in 2..64.
  function automatic logic [63:0] umax_f(int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

  function automatic logic [63:0] smax_f(int w);
    return {64{1'b1}} >> (65 - w);
  endfunction

  function automatic logic [63:0] smin_f(int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/conv_mac_mul_pipe.sv
// ce-gated multiplier pipeline; the product is extended to the
// accumulator width before it enters the first stage.
module conv_mac_mul_pipe
  import conv_mac_pkg::*;
#(
  parameter int D0W  = DIN0_W,
  parameter int D1W  = DIN1_W,
  parameter int ACCW = ACC_W,
  parameter int NS   = NSTAGE
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            ce,
  input  logic            valid,
  input  logic            last,
  input  logic            mode,
  input  logic [D0W-1:0]  din0,
  input  logic [D1W-1:0]  din1,
  output logic [ACCW-1:0] prod,
  output side_t           side_out
);

  localparam int PW = D0W + D1W;

  logic signed [PW-1:0] ps;
  logic [PW-1:0]        pu;
  logic [ACCW-1:0]      ext;
  logic [ACCW-1:0]      data [NS];
  side_t                side [NS];

  assign ps = PW'($signed(din0)) * PW'($signed(din1));
  assign pu = PW'(din0) * PW'(din1);

  always_comb begin
    ext = ACCW'(pu);
    if (mode) ext = ACCW'(ps);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NS; i++) begin
        data[i] <= '0;
        side[i] <= '0;
      end
    end else if (ce) begin
      data[0] <= ext;
      side[0] <= '{valid: valid, last: last, mode: mode};
      for (int i = 1; i < NS; i++) begin
        data[i] <= data[i-1];
        side[i] <= side[i-1];
      end
    end
  end

  assign prod     = data[NS-1];
  assign side_out = side[NS-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// Streaming dot-product engine: pipelined multiply, accumulate,
// wrap or saturate, one result per in_last beat.
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_W,
  parameter int DIN1_WIDTH = DIN1_W,
  parameter int ACC_WIDTH  = ACC_W,
  parameter int NUM_STAGE  = NSTAGE,
  parameter int CNT_WIDTH  = CNT_W,
  parameter int SATURATE   = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]  out_beats,
  output logic                  out_ovf
);

  localparam int M = ACC_WIDTH - 1;
  localparam logic [M:0] UMAX = ACC_WIDTH'(umax_f(ACC_WIDTH));
  localparam logic [M:0] SMAX = ACC_WIDTH'(smax_f(ACC_WIDTH));
  localparam logic [M:0] SMIN = ACC_WIDTH'(smin_f(ACC_WIDTH));

  logic           ce;
  logic           accept;
  state_t         state;
  logic           mode_q;
  logic           beat_mode;
  logic [M:0]     prod;
  side_t          pside;
  logic [M:0]     acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic           ovf;
  logic [M+1:0]   sum_ext;
  logic [M:0]     sum;
  logic           ovf_now;
  logic [M:0]     res;

  assign ce       = !out_valid || out_ready;
  assign in_ready = ce;
  assign accept   = in_valid && ce;

  // The first beat of a dot product sets the mode for all its beats.
  assign beat_mode = (state == IDLE) ? in_signed : mode_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      mode_q <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) mode_q <= in_signed;
      state <= in_last ? IDLE : ACCUM;
    end
  end

  conv_mac_mul_pipe #(
    .D0W (DIN0_WIDTH),
    .D1W (DIN1_WIDTH),
    .ACCW(ACC_WIDTH),
    .NS  (NUM_STAGE)
  ) u_mul (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .ce      (ce),
    .valid   (accept),
    .last    (in_last),
    .mode    (beat_mode),
    .din0    (din0),
    .din1    (din1),
    .prod    (prod),
    .side_out(pside)
  );

  assign sum_ext  = {1'b0, acc} + {1'b0, prod};
  assign sum      = sum_ext[M:0];
  assign cnt_next = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);

  always_comb begin
    ovf_now = sum_ext[M+1];
    if (pside.mode)
      ovf_now = (acc[M] == prod[M]) && (sum[M] != acc[M]);
    res = sum;
    if (ovf_now && SATURATE != 0) begin
      unique case (1'b1)
        !pside.mode: res = UMAX;
        prod[M]:     res = SMIN;
        default:     res = SMAX;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (ce) begin
      if (out_valid) out_valid <= 1'b0;
      if (pside.valid) begin
        if (pside.last) begin
          out_valid <= 1'b1;
          out_data  <= res;
          out_beats <= cnt_next;
          out_ovf   <= ovf | ovf_now;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= res;
          cnt <= cnt_next;
          ovf <= ovf | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench: one 32-bit wrapping instance and two 24-bit
// instances (wrap, saturate) fed the same beat stream.
module tb_conv_mac_pipe;

  typedef struct {
    longint data;
    longint beats;
    bit     ovf;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  din0 = '0;
  logic [13:0] din1 = '0;
  logic        in_signed = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [31:0] out_data0;
  logic [23:0] out_data1, out_data2;
  logic [15:0] out_beats0, out_beats1, out_beats2;
  logic        out_ovf0, out_ovf1, out_ovf2;

  int total = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  longint macc[3];
  bit     movf[3];
  longint mcnt;
  bit     mmode;
  bit     in_dp;

  always #5 ap_clk = ~ap_clk;

  conv_mac_pipe u_dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_beats(out_beats0),
    .out_ovf(out_ovf0)
  );

  conv_mac_pipe #(.ACC_WIDTH(24), .SATURATE(0)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_beats(out_beats1),
    .out_ovf(out_ovf1)
  );

  conv_mac_pipe #(.ACC_WIDTH(24), .SATURATE(1)) u_dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_beats(out_beats2),
    .out_ovf(out_ovf2)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
    end
    mcnt  = 0;
    in_dp = 1'b0;
  endtask

  // Reference: exact 64-bit sum, then range check per instance.
  task automatic model_beat(input logic [7:0] a, input logic [13:0] b,
                            input logic sg, input logic last);
    longint p, t, span, hi, lo;
    exp_t e;
    if (!in_dp) mmode = sg;
    in_dp = !last;
    if (mmode) p = longint'($signed(a)) * longint'($signed(b));
    else       p = longint'(a) * longint'(b);
    if (mcnt < 65535) mcnt++;
    for (int k = 0; k < 3; k++) begin
      span = 64'sd1 << ((k == 0) ? 32 : 24);
      hi = mmode ? span / 2 - 1 : span - 1;
      lo = mmode ? -(span / 2) : 0;
      t = macc[k] + p;
      if (t > hi) begin
        movf[k] = 1'b1;
        macc[k] = (k == 2) ? hi : t - span;
      end else if (t < lo) begin
        movf[k] = 1'b1;
        macc[k] = (k == 2) ? lo : t + span;
      end else begin
        macc[k] = t;
      end
      if (last) begin
        e.data  = macc[k] & (span - 1);
        e.beats = mcnt;
        e.ovf   = movf[k];
        case (k)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
        macc[k] = 0;
        movf[k] = 1'b0;
      end
    end
    if (last) mcnt = 0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [13:0] b,
                           input logic sg, input logic last);
    int  n;
    bit  ok;
    din0 = a;
    din1 = b;
    in_signed = sg;
    in_last = last;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge ap_clk);
      ok = in_ready0;
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else model_beat(a, b, sg, last);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("drain", q0.size() + q1.size() + q2.size(), 0);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("d0_spurious", 1, 0);
      else begin
        e = q0.pop_front();
        chk("d0_data", out_data0, e.data);
        chk("d0_beats", out_beats0, e.beats);
        chk("d0_ovf", out_ovf0, e.ovf);
      end
    end
  end

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("d1_spurious", 1, 0);
      else begin
        e = q1.pop_front();
        chk("d1_data", out_data1, e.data);
        chk("d1_beats", out_beats1, e.beats);
        chk("d1_ovf", out_ovf1, e.ovf);
      end
    end
  end

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && out_valid2 && out_ready) begin
      if (q2.size() == 0) chk("d2_spurious", 1, 0);
      else begin
        e = q2.pop_front();
        chk("d2_data", out_data2, e.data);
        chk("d2_beats", out_beats2, e.beats);
        chk("d2_ovf", out_ovf2, e.ovf);
      end
    end
  end

  initial begin
    int lat;
    logic [7:0]  ra;
    logic [13:0] rb;
    int len;
    bit sg;

    model_clear();
    mmode = 1'b0;
    @(negedge ap_clk);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_beats", out_beats0, 0);
    chk("rst_out_ovf", out_ovf0, 0);
    chk("rst_in_ready", in_ready0, 1);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // unsigned single beat, latency in cycles from the accept cycle
    send_beat(8'd255, 14'd16383, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid0 && lat < 50) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
    @(negedge ap_clk);
    chk("single_u_data", out_data0, 4177665);
    wait_drain();

    send_beat(8'h80, 14'd8191, 1'b1, 1'b1);
    wait_drain();

    // back-to-back dot products; mode ignored after first beat
    send_beat(8'd2, 14'd3, 1'b0, 1'b0);
    send_beat(8'd4, 14'd5, 1'b1, 1'b0);
    send_beat(8'd6, 14'd7, 1'b1, 1'b1);
    send_beat(8'd1, 14'd1, 1'b0, 1'b1);
    wait_drain();

    for (int i = 0; i < 5; i++)
      send_beat(8'd255, 14'd16383, 1'b0, i == 4);
    wait_drain();

    for (int i = 0; i < 8; i++)
      send_beat(8'h80, 14'h2000, 1'b1, i == 7);
    for (int i = 0; i < 9; i++)
      send_beat(8'h80, 14'd8191, 1'b1, i == 8);
    wait_drain();

    // downstream stall with more beats queued behind it
    out_ready = 1'b0;
    send_beat(8'd10, 14'd20, 1'b0, 1'b1);
    fork
      begin
        int n;
        n = 0;
        while (!out_valid0 && n < 50) begin
          @(posedge ap_clk);
          #1;
          n++;
        end
        chk("stall_valid", out_valid0, 1);
        repeat (5) begin
          @(negedge ap_clk);
          chk("stall_in_ready", in_ready0, 0);
          chk("stall_data", out_data0, 200);
          chk("stall_beats", out_beats0, 1);
        end
        @(posedge ap_clk);
        #1 out_ready = 1'b1;
      end
      begin
        send_beat(8'd5, 14'd5, 1'b0, 1'b0);
        send_beat(8'd6, 14'd6, 1'b0, 1'b1);
        send_beat(8'd7, 14'd7, 1'b0, 1'b1);
        send_beat(8'd8, 14'd8, 1'b0, 1'b1);
      end
    join
    wait_drain();

    // reset in the middle of a dot product
    send_beat(8'd1, 14'd2, 1'b0, 1'b0);
    send_beat(8'd3, 14'd4, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    model_clear();
    @(negedge ap_clk);
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_in_ready", in_ready0, 1);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    send_beat(8'd3, 14'd3, 1'b0, 1'b1);
    wait_drain();

    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 4);
      sg = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        ra = 8'($urandom);
        rb = 14'($urandom);
        send_beat(ra, rb, (j == 0) ? sg : 1'($urandom_range(0, 1)),
                  j == len - 1);
      end
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
